// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder.
// Nibble width, default operand width and FSM state encodings.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/adder_4bits.sv
// 4-bit carry-lookahead adder.
// All carries are formed directly from generate/propagate terms.
module adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // lookahead carries, no ripple between bit positions
  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
  end

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder: one nibble per clock, LSB first.
// Valid/ready on both sides; result held until consumed.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int N  = WIDTH / NIBBLE_W;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]          state;
  logic [WIDTH-1:0]    a_sh;
  logic [WIDTH-1:0]    b_sh;
  logic                carry;
  logic [CW-1:0]       k;
  logic [WIDTH-1:0]    s_q;
  logic                co_q;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  adder_4bits u_add (
    .a  (a_sh[NIBBLE_W-1:0]),
    .b  (b_sh[NIBBLE_W-1:0]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign s         = s_q;
  assign co        = co_q;

  // FSM, operand shifters, carry and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      k     <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ci;
            k     <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_q[int'(k)*NIBBLE_W +: NIBBLE_W] <= nib_s;
          carry <= nib_co;
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          if (k == LAST) begin
            k     <= '0;
            co_q  <= nib_co;
            state <= ST_DONE;
          end else begin
            k <= k + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks for nibble_serial_adder.
// Inputs driven 1ns after posedge, outputs sampled there too.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        co;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept an operation, measure latency, check result, then consume
  task automatic run_op(input logic [15:0] ta,
                        input logic [15:0] tb,
                        input logic        tci,
                        input logic [15:0] es,
                        input logic        eco,
                        input int          stall);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 10) begin
      tick();
      w++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    ci = tci;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    ci = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("s", 32'(s), 32'(es));
    chk("co", 32'(co), 32'(eco));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [16:0] ref_sum;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    int          cnt;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    ci = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_co", 32'(co), 32'd0);

    // idle with in_valid low stays idle
    tick();
    tick();
    chk("idle_hold", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1);

    // stale carry must not leak into the next op
    run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 0);

    // stall with in_valid churn: result held
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    ci = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      ci = 1'($urandom);
      tick();
      chk("stall_s", 32'(s), 32'hBCDF);
      chk("stall_co", 32'(co), 32'd0);
      chk("stall_rdy", 32'(in_ready), 32'd0);
      chk("stall_ov", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_rdy", 32'(in_ready), 32'd1);
    chk("post_hs_ov", 32'(out_valid), 32'd0);
    chk("post_hs_s", 32'(s), 32'hBCDF);

    // reset in the middle of RUN
    in_valid = 1'b1;
    a = 16'h7777;
    b = 16'h1111;
    ci = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("mid_rst_noov", 32'(cnt), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0);

    // reset together with in_valid captures nothing
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_iv_rdy", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("rst_iv_noov", 32'(cnt), 32'd0);

    // randomized back-to-back with stalls
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      run_op(ra, rb, rc, ref_sum[15:0], ref_sum[16],
             int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
